uart_cmd_sequencer: RTL and testbench

Command sequencer between the chip's UART receiver/transmitter pair and the configuration register file inside `digital_core`. It unloads 18-bit command packets from `uart_rx`, checks parity and address range, and performs the register write or read. It then hands a response packet to `uart_tx`, with one command outstanding at a time. It is the sole master of the regfile write port and the sole loader of the UART transmitter.

---
 rtl/uart_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Brief    : Unloads UART command packets, accesses the config regfile and
//            returns a response packet, one command in flight at a time.
// Revision : 1.0
// ============================================================================
module uart_cmd_sequencer #(
   parameter int NUMREGS = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [17:0] rx_data,
   input  logic        rx_empty,
   output logic        uld_rx_data,
   output logic [17:0] tx_data,
   output logic        ld_tx_data,
   input  logic        tx_busy,
   output logic [7:0]  reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   input  logic [7:0]  reg_rdata,
   output logic [7:0]  parity_err_cnt,
   output logic [7:0]  addr_err_cnt,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_UNLOAD  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_EXEC    = 3'd3,
      ST_TX_WAIT = 3'd4,
      ST_TX_LOAD = 3'd5
   } state_t;

   localparam logic [8:0] C_NUMREGS = 9'(NUMREGS);

   state_t      r_state;
   logic [17:0] r_cmd;
   logic        r_uld;
   logic        r_ld;
   logic        r_reg_we;
   logic [7:0]  r_reg_addr;
   logic [7:0]  r_reg_wdata;
   logic [17:0] r_tx_data;
   logic [7:0]  r_perr_cnt;
   logic [7:0]  r_aerr_cnt;
   logic        r_busy;

   logic        w_rx_par_ok;
   logic [7:0]  w_rx_addr;
   logic        w_rx_in_range;
   logic        w_cmd_par_ok;
   logic [7:0]  w_cmd_addr;
   logic        w_cmd_in_range;
   logic        w_cmd_wrb;
   logic [7:0]  w_rsp_data;
   logic [16:0] w_rsp_body;
   logic [17:0] w_rsp;

   // Odd parity: a good packet has an odd number of ones across all 18 bits.
   assign w_rx_par_ok    = ^rx_data;
   assign w_rx_addr      = rx_data[16:9];
   assign w_rx_in_range  = ({1'b0, w_rx_addr} < C_NUMREGS);

   assign w_cmd_par_ok   = ^r_cmd;
   assign w_cmd_addr     = r_cmd[16:9];
   assign w_cmd_in_range = ({1'b0, w_cmd_addr} < C_NUMREGS);
   assign w_cmd_wrb      = r_cmd[0];

   assign w_rsp_data = !w_cmd_wrb      ? r_cmd[8:1] :
                       w_cmd_in_range ? reg_rdata  : 8'h00;
   assign w_rsp_body = {w_cmd_addr, w_rsp_data, w_cmd_wrb};
   assign w_rsp      = {~^w_rsp_body, w_rsp_body};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cmd       <= 18'h0;
         r_uld       <= 1'b0;
         r_ld        <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_addr  <= 8'h00;
         r_reg_wdata <= 8'h00;
         r_tx_data   <= 18'h0;
         r_perr_cnt  <= 8'h00;
         r_aerr_cnt  <= 8'h00;
         r_busy      <= 1'b0;
      end else begin
         r_uld    <= 1'b0;
         r_reg_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!rx_empty) begin
                  r_state <= ST_UNLOAD;
                  r_uld   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_UNLOAD: begin
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // Regfile strobe is prepared from the raw packet so it lands in EXEC.
               r_cmd   <= rx_data;
               r_state <= ST_EXEC;
               if (w_rx_par_ok) begin
                  r_reg_addr <= w_rx_addr;
                  if (!rx_data[0]) begin
                     r_reg_wdata <= rx_data[8:1];
                     r_reg_we    <= w_rx_in_range;
                  end
               end
            end
            ST_EXEC: begin
               if (!w_cmd_par_ok) begin
                  if (r_perr_cnt != 8'hFF) r_perr_cnt <= r_perr_cnt + 8'd1;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (!w_cmd_in_range && (r_aerr_cnt != 8'hFF))
                     r_aerr_cnt <= r_aerr_cnt + 8'd1;
                  r_tx_data <= w_rsp;
                  r_state   <= ST_TX_WAIT;
               end
            end
            ST_TX_WAIT: begin
               if (!tx_busy) begin
                  r_state <= ST_TX_LOAD;
                  r_ld    <= 1'b1;
               end
            end
            ST_TX_LOAD: begin
               if (tx_busy) begin
                  r_ld    <= 1'b0;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ld    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign uld_rx_data    = r_uld;
   assign tx_data        = r_tx_data;
   assign ld_tx_data     = r_ld;
   assign reg_addr       = r_reg_addr;
   assign reg_wdata      = r_reg_wdata;
   assign reg_we         = r_reg_we;
   assign parity_err_cnt = r_perr_cnt;
   assign addr_err_cnt   = r_aerr_cnt;
   assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Brief    : Directed vector bench for uart_cmd_sequencer with a small
//            regfile and uart_tx responder.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_sequencer;

   logic        clk;
   logic        reset_n;
   logic [17:0] rx_data;
   logic        rx_empty;
   logic        uld_rx_data;
   logic [17:0] tx_data;
   logic        ld_tx_data;
   logic        tx_busy;
   logic [7:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_we;
   logic [7:0]  reg_rdata;
   logic [7:0]  parity_err_cnt;
   logic [7:0]  addr_err_cnt;
   logic        busy;

   uart_cmd_sequencer #(.NUMREGS(64)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_data        (rx_data),
      .rx_empty       (rx_empty),
      .uld_rx_data    (uld_rx_data),
      .tx_data        (tx_data),
      .ld_tx_data     (ld_tx_data),
      .tx_busy        (tx_busy),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_we         (reg_we),
      .reg_rdata      (reg_rdata),
      .parity_err_cnt (parity_err_cnt),
      .addr_err_cnt   (addr_err_cnt),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Regfile model; out-of-range reads return junk the DUT must mask.
   logic [7:0]  regs [0:63] = '{default: 8'h00};
   int          n_we = 0;
   logic [7:0]  we_addr = 8'h00;
   logic [7:0]  we_data = 8'h00;
   assign reg_rdata = (reg_addr < 8'd64) ? regs[reg_addr[5:0]] : 8'hEE;

   // uart_tx responder controls
   logic        hold_busy = 1'b0;
   logic        no_accept = 1'b0;
   logic [17:0] tx_q [$];

   typedef struct {
      logic [17:0] pkt;
      logic        we;
      logic [7:0]  we_addr;
      logic [7:0]  we_data;
      logic        tx;
      logic [17:0] tx_pkt;
      logic [7:0]  perr;
      logic [7:0]  aerr;
   } vec_t;

   vec_t vecs [10];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reg_we === 1'b1) begin
            n_we++;
            we_addr = reg_addr;
            we_data = reg_wdata;
            if (reg_addr < 8'd64) regs[reg_addr[5:0]] = reg_wdata;
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0;
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            tx_busy = 1'b0;
            cnt = 0;
         end else if (hold_busy) begin
            tx_busy = 1'b1;
         end else if (cnt != 0) begin
            cnt--;
            if (cnt == 0) tx_busy = 1'b0;
         end else if (ld_tx_data && !no_accept) begin
            tx_q.push_back(tx_data);
            tx_busy = 1'b1;
            cnt = 3;
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy !== 1'b0 && i < 80) begin
         @(negedge clk);
         i++;
      end
      if (busy !== 1'b0) timeout("wait_idle");
   endtask

   task automatic send(input logic [17:0] pkt);
      int i;
      @(posedge clk);
      #1;
      rx_data  = pkt;
      rx_empty = 1'b0;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (uld_rx_data !== 1'b1 && i < 20);
      rx_empty = 1'b1;
      if (uld_rx_data !== 1'b1) timeout("send_unload");
      wait_idle();
   endtask

   initial begin
      int          we0;
      int          q0;
      int          n_uld;
      int          n_ld;
      logic        s_uld [0:6];
      logic        s_we  [0:6];
      logic        s_ld  [0:6];
      logic        s_busy1;
      logic [6:0]  exp_uld;
      logic [6:0]  exp_we;
      logic [6:0]  exp_ld;
      int          i;

      vecs[0] = '{18'h2074A, 1'b1, 8'h03, 8'hA5, 1'b1, 18'h2074A, 8'd0, 8'd0};
      vecs[1] = '{18'h00601, 1'b0, 8'h00, 8'h00, 1'b1, 18'h0074B, 8'd0, 8'd0};
      vecs[2] = '{18'h0074A, 1'b0, 8'h00, 8'h00, 1'b0, 18'h00000, 8'd1, 8'd0};
      vecs[3] = '{18'h00601, 1'b0, 8'h00, 8'h00, 1'b1, 18'h0074B, 8'd1, 8'd0};
      vecs[4] = '{18'h28001, 1'b0, 8'h00, 8'h00, 1'b1, 18'h28001, 8'd1, 8'd1};
      vecs[5] = '{18'h08024, 1'b0, 8'h00, 8'h00, 1'b1, 18'h08024, 8'd1, 8'd2};
      vecs[6] = '{18'h27FFE, 1'b1, 8'h3F, 8'hFF, 1'b1, 18'h27FFE, 8'd1, 8'd2};
      vecs[7] = '{18'h07E01, 1'b0, 8'h00, 8'h00, 1'b1, 18'h07FFF, 8'd1, 8'd2};
      vecs[8] = '{18'h1FE01, 1'b0, 8'h00, 8'h00, 1'b1, 18'h1FE01, 8'd1, 8'd3};
      vecs[9] = '{18'h00AEF, 1'b0, 8'h00, 8'h00, 1'b1, 18'h00A01, 8'd1, 8'd3};

      reset_n  = 1'b0;
      rx_data  = 18'h0;
      rx_empty = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_uld",  32'(uld_rx_data), 32'd0);
      chk("rst_ld",   32'(ld_tx_data), 32'd0);
      chk("rst_we",   32'(reg_we), 32'd0);
      chk("rst_tx",   32'(tx_data), 32'd0);
      chk("rst_addr", 32'(reg_addr), 32'd0);
      chk("rst_wdat", 32'(reg_wdata), 32'd0);
      chk("rst_perr", 32'(parity_err_cnt), 32'd0);
      chk("rst_aerr", 32'(addr_err_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 10; v++) begin
         we0 = n_we;
         q0  = tx_q.size();
         send(vecs[v].pkt);
         chk($sformatf("v%0d_we_cnt", v), 32'(n_we - we0), 32'(vecs[v].we));
         if (vecs[v].we) begin
            chk($sformatf("v%0d_we_addr", v), 32'(we_addr), 32'(vecs[v].we_addr));
            chk($sformatf("v%0d_we_data", v), 32'(we_data), 32'(vecs[v].we_data));
         end
         chk($sformatf("v%0d_tx_cnt", v), 32'(tx_q.size() - q0), 32'(vecs[v].tx));
         if (vecs[v].tx && tx_q.size() > q0)
            chk($sformatf("v%0d_tx_pkt", v), 32'(tx_q[tx_q.size()-1]), 32'(vecs[v].tx_pkt));
         chk($sformatf("v%0d_perr", v), 32'(parity_err_cnt), 32'(vecs[v].perr));
         chk($sformatf("v%0d_aerr", v), 32'(addr_err_cnt), 32'(vecs[v].aerr));
      end

      // Cycle-accurate timing from rx_empty falling in cycle 0
      repeat (8) @(negedge clk);
      q0 = tx_q.size();
      @(posedge clk);
      #1;
      rx_data  = 18'h2074A;
      rx_empty = 1'b0;
      s_busy1  = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         s_uld[c] = uld_rx_data;
         s_we[c]  = reg_we;
         s_ld[c]  = ld_tx_data;
         if (c == 1) begin
            rx_empty = 1'b1;
            s_busy1  = busy;
         end
      end
      exp_uld = 7'b0000010;
      exp_we  = 7'b0001000;
      exp_ld  = 7'b0100000;
      for (int c = 0; c < 7; c++) begin
         chk($sformatf("tim_uld_c%0d", c), 32'(s_uld[c]), 32'(exp_uld[c]));
         chk($sformatf("tim_we_c%0d", c),  32'(s_we[c]),  32'(exp_we[c]));
         chk($sformatf("tim_ld_c%0d", c),  32'(s_ld[c]),  32'(exp_ld[c]));
      end
      chk("tim_busy_c1", 32'(s_busy1), 32'd1);
      wait_idle();
      chk("tim_tx_cnt", 32'(tx_q.size() - q0), 32'd1);
      if (tx_q.size() > q0) chk("tim_tx_pkt", 32'(tx_q[tx_q.size()-1]), 32'h2074A);

      // Backpressure: tx_busy held with a second packet waiting
      repeat (8) @(negedge clk);
      q0 = tx_q.size();
      hold_busy = 1'b1;
      @(posedge clk);
      #1;
      rx_data  = 18'h00601;
      rx_empty = 1'b0;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (uld_rx_data !== 1'b1 && i < 20);
      if (uld_rx_data !== 1'b1) timeout("bp_first_unload");
      repeat (2) @(negedge clk);
      rx_data = 18'h27FFE;
      n_uld = 0;
      n_ld  = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (uld_rx_data) n_uld++;
         if (ld_tx_data)  n_ld++;
      end
      chk("bp_no_unload", 32'(n_uld), 32'd0);
      chk("bp_no_load",   32'(n_ld), 32'd0);
      chk("bp_busy",      32'(busy), 32'd1);
      hold_busy = 1'b0;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (uld_rx_data !== 1'b1 && i < 40);
      rx_empty = 1'b1;
      if (uld_rx_data !== 1'b1) timeout("bp_second_unload");
      wait_idle();
      chk("bp_tx_cnt", 32'(tx_q.size() - q0), 32'd2);
      if (tx_q.size() >= q0 + 2) begin
         chk("bp_tx_first",  32'(tx_q[q0]),   32'h0074B);
         chk("bp_tx_second", 32'(tx_q[q0+1]), 32'h27FFE);
      end

      // Reset asserted while parked in TX_LOAD
      repeat (8) @(negedge clk);
      no_accept = 1'b1;
      @(posedge clk);
      #1;
      rx_data  = 18'h00601;
      rx_empty = 1'b0;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (uld_rx_data !== 1'b1 && i < 20);
      rx_empty = 1'b1;
      i = 0;
      while (ld_tx_data !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (ld_tx_data !== 1'b1) timeout("rst_mid_load");
      @(negedge clk);
      chk("ld_held", 32'(ld_tx_data), 32'd1);
      chk("ld_held_tx", 32'(tx_data), 32'h0074B);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ld",   32'(ld_tx_data), 32'd0);
      chk("mid_rst_tx",   32'(tx_data), 32'd0);
      chk("mid_rst_addr", 32'(reg_addr), 32'd0);
      chk("mid_rst_uld",  32'(uld_rx_data), 32'd0);
      chk("mid_rst_we",   32'(reg_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_perr", 32'(parity_err_cnt), 32'd0);
      chk("mid_rst_aerr", 32'(addr_err_cnt), 32'd0);
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      no_accept = 1'b0;
      n_uld = 0;
      n_ld  = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (uld_rx_data) n_uld++;
         if (ld_tx_data)  n_ld++;
      end
      chk("post_rst_no_unload", 32'(n_uld), 32'd0);
      chk("post_rst_no_load",   32'(n_ld), 32'd0);
      chk("post_rst_busy",      32'(busy), 32'd0);
      q0 = tx_q.size();
      send(18'h00601);
      chk("post_rst_tx_cnt", 32'(tx_q.size() - q0), 32'd1);
      if (tx_q.size() > q0) chk("post_rst_tx_pkt", 32'(tx_q[tx_q.size()-1]), 32'h0074B);

      // Parity counter saturation
      we0 = n_we;
      q0  = tx_q.size();
      for (int k = 0; k < 300; k++) begin
         send(18'h0074A);
         if (k == 254) chk("sat_perr_255", 32'(parity_err_cnt), 32'hFF);
      end
      chk("sat_perr", 32'(parity_err_cnt), 32'hFF);
      chk("sat_aerr", 32'(addr_err_cnt), 32'h00);
      chk("sat_no_we", 32'(n_we - we0), 32'd0);
      chk("sat_no_tx", 32'(tx_q.size() - q0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
